seg7_scan_driver: RTL and testbench

- Downstream consumer of the 4-digit BCD counter chain; takes its 16-bit packed BCD value and drives a 4-digit multiplexed common-anode 7-segment display.
- Time-multiplexes one digit per prescaler tick and snapshots the input once per frame, so no digit shows a torn value mid-scan.
- Provides leading-zero blanking, per-digit decimal points and a display enable.

---
 rtl/seg7_scan_driver_pkg.sv | 22 ++
 rtl/seg7_scan_driver_bcd_to_seg7.sv | 27 ++
 rtl/seg7_scan_driver.sv | 96 +++++++++
 tb/tb_seg7_scan_driver.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver: active-low segment codes, digit count.
// Pure definitions; no latency and no flow control.
package seg7_scan_driver_pkg;

    localparam int DIGITS = 4;
    localparam int IDX_W  = $clog2(DIGITS);

    // Segment patterns are {g,f,e,d,c,b,a}, active low.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// BCD nibble to active-low 7-segment pattern; codes A-F render as a dash.
// Purely combinational, zero latency; no flow control.
module bcd_to_seg7
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Scans a 4-digit BCD value onto a common-anode display, one digit per DIV-cycle slot, snapshotting per frame.
// Outputs lag the digit index by one cycle; no backpressure, the scan free-runs.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        lzb,
    input  logic [3:0]  dp,
    input  logic [15:0] bcd_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        frame
);

    localparam int            CW       = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      snap_q, snap_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_n_q, dp_n_d;
    logic             frame_q, frame_d;

    logic              tick;
    logic              last_digit;
    logic [3:0]        cur_code;
    logic [6:0]        cur_seg;
    logic [DIGITS-1:0] zero_from;

    assign tick       = (cnt_q == CNT_LAST);
    assign last_digit = (idx_q == IDX_W'(DIGITS - 1));
    assign cur_code   = snap_q[{idx_q, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .code (cur_code),
        .seg  (cur_seg)
    );

    // zero_from[i]: snapshot digits i..3 are all zero; A-F never counts as zero.
    always_comb begin
        zero_from = '0;
        zero_from[DIGITS-1] = (snap_q[4*(DIGITS-1) +: 4] == 4'h0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (snap_q[4*i +: 4] == 4'h0);
        end
    end

    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        idx_d   = tick ? idx_q + 1'b1 : idx_q;
        snap_d  = (tick && last_digit) ? bcd_in : snap_q;
        frame_d = tick && last_digit;
    end

    always_comb begin
        an_d   = en ? ~(4'b0001 << idx_q) : 4'b1111;
        dp_n_d = ~dp[idx_q];
        seg_d  = cur_seg;
        if (lzb && (idx_q != '0) && zero_from[idx_q]) begin
            seg_d = SEG_BLANK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            snap_q  <= 16'h0000;
            an_q    <= 4'b1111;
            seg_q   <= SEG_BLANK;
            dp_n_q  <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_n_q  <= dp_n_d;
            frame_q <= frame_d;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign dp_n  = dp_n_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver at DIV=4: directed frames, expected digit slots queued, monitor checks mid-slot.
// Slot s (since reset release) is visible after clock edges 4s+1..4s+4 and checked after edge 4s+2.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst;
    logic        en;
    logic        lzb;
    logic [3:0]  dp;
    logic [15:0] bcd_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame;

    int tests = 0;
    int fails = 0;
    int k     = 0;

    typedef struct {
        int         slot;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp_n;
    } exp_t;

    exp_t exp_q[$];

    seg7_scan_driver #(.DIV(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .lzb    (lzb),
        .dp     (dp),
        .bcd_in (bcd_in),
        .an     (an),
        .seg    (seg),
        .dp_n   (dp_n),
        .frame  (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    task automatic chk(input string name, input int slot, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s slot %0d: got %0h, expected %0h", name, slot, act, exp);
        end
    endtask

    task automatic push(input int slot, input logic [3:0] a, input logic [6:0] s, input logic d);
        exp_t e;
        e.slot = slot;
        e.an   = a;
        e.seg  = s;
        e.dp_n = d;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input int f, input logic on,
                              input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic [3:0] dpm);
        logic [6:0] s[4];
        logic [3:0] oh;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int d = 0; d < 4; d++) begin
            oh = 4'b0001 << d;
            push(4*f + d, on ? ~oh : 4'b1111, s[d], ~dpm[d]);
        end
    endtask

    task automatic wait_k(input int n);
        int i;
        i = 0;
        while (k != n && i < 5000) begin
            @(negedge clk);
            i++;
        end
        if (k != n) begin
            tests++;
            fails++;
            $display("FAIL wait_k: cycle count %0d, expected %0d", k, n);
        end
    endtask

    // Monitor: frame model every cycle, queued digit expectations mid-slot.
    always @(negedge clk) begin
        if (!rst && k > 0) begin
            chk("frame", (k - 1) / 4, {15'd0, frame}, {15'd0, (k % 16) == 0});
            if (k % 4 == 2) begin
                while (exp_q.size() > 0 && exp_q[0].slot < (k - 2) / 4) begin
                    tests++;
                    fails++;
                    $display("FAIL missed_slot slot %0d: got nothing, expected check", exp_q[0].slot);
                    void'(exp_q.pop_front());
                end
                if (exp_q.size() > 0 && exp_q[0].slot == (k - 2) / 4) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("an",   e.slot, {12'd0, an},   {12'd0, e.an});
                    chk("seg",  e.slot, {9'd0, seg},   {9'd0, e.seg});
                    chk("dp_n", e.slot, {15'd0, dp_n}, {15'd0, e.dp_n});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        en     = 1'b1;
        lzb    = 1'b0;
        dp     = 4'b0000;
        bcd_in = 16'h1234;
        repeat (3) @(negedge clk);
        chk("rst_an",    -1, {12'd0, an},   16'h000F);
        chk("rst_seg",   -1, {9'd0, seg},   16'h007F);
        chk("rst_dp_n",  -1, {15'd0, dp_n}, 16'h0001);
        chk("rst_frame", -1, {15'd0, frame}, 16'h0000);

        // Frame 0 shows the cleared snapshot; frame 1 shows 1234.
        push_frame(0, 1'b1, 7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);
        push_frame(1, 1'b1, 7'h19, 7'h30, 7'h24, 7'h79, 4'b0000);
        rst = 1'b0;

        wait_k(16);
        bcd_in = 16'h0070;
        wait_k(32);
        lzb    = 1'b1;
        bcd_in = 16'h0000;
        push_frame(2, 1'b1, 7'h40, 7'h78, 7'h7F, 7'h7F, 4'b0000);
        wait_k(48);
        bcd_in = 16'h1111;
        push_frame(3, 1'b1, 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0000);
        wait_k(64);
        lzb = 1'b0;
        push_frame(4, 1'b1, 7'h79, 7'h79, 7'h79, 7'h79, 4'b0000);
        // Mid-frame change while digit 1 is scanning must not tear frame 4.
        wait_k(69);
        bcd_in = 16'h9999;
        wait_k(80);
        bcd_in = 16'hA0F5;
        push_frame(5, 1'b1, 7'h10, 7'h10, 7'h10, 7'h10, 4'b0000);
        wait_k(96);
        push_frame(6, 1'b1, 7'h12, 7'h3F, 7'h40, 7'h3F, 4'b0000);
        wait_k(112);
        lzb = 1'b1;
        push_frame(7, 1'b1, 7'h12, 7'h3F, 7'h40, 7'h3F, 4'b0000);
        wait_k(128);
        lzb = 1'b0;
        en  = 1'b0;
        push_frame(8, 1'b0, 7'h12, 7'h3F, 7'h40, 7'h3F, 4'b0000);
        push_frame(9, 1'b0, 7'h12, 7'h3F, 7'h40, 7'h3F, 4'b0000);
        wait_k(160);
        en     = 1'b1;
        dp     = 4'b0100;
        bcd_in = 16'h5678;
        push_frame(10, 1'b1, 7'h12, 7'h3F, 7'h40, 7'h3F, 4'b0100);
        wait_k(176);
        push(44, 4'hE, 7'h00, 1'b1);
        push(45, 4'hD, 7'h78, 1'b1);
        push(46, 4'hB, 7'h02, 1'b0);

        // Asynchronous reset in the middle of digit 2 of the 5678 frame.
        wait_k(186);
        #2;
        chk("pre_rst_an",  46, {12'd0, an},  16'h000B);
        chk("pre_rst_seg", 46, {9'd0, seg},  16'h0002);
        rst = 1'b1;
        #1;
        chk("async_rst_an",    46, {12'd0, an},    16'h000F);
        chk("async_rst_seg",   46, {9'd0, seg},    16'h007F);
        chk("async_rst_dp_n",  46, {15'd0, dp_n},  16'h0001);
        chk("async_rst_frame", 46, {15'd0, frame}, 16'h0000);
        repeat (2) @(negedge clk);
        push_frame(0, 1'b1, 7'h40, 7'h40, 7'h40, 7'h40, 4'b0100);
        push(4, 4'hE, 7'h00, 1'b1);
        rst = 1'b0;

        wait_k(24);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL leftover_expect: got %0d unchecked entries, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
